// File: rtl/rx_command_decoder.sv
// Frames UART RX bytes into sudoku host commands: event code plus fixed-length payload,
// range-checked, published with a one-cycle data_valid or dropped with frame_error.
module rx_command_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] evento,
    output logic [7:0] arg0,
    output logic [7:0] arg1,
    output logic [7:0] arg2,
    output logic       data_valid,
    output logic       frame_error,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StPayload = 1'b1;

    localparam logic [7:0] EvStart = 8'hA0;
    localparam logic [7:0] EvPlace = 8'hA1;
    localparam logic [7:0] EvEnd   = 8'hAB;

    localparam logic [1:0] ErrUnknown = 2'b01;
    localparam logic [1:0] ErrRange   = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    localparam logic [31:0] TcntLast = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic is_known(input logic [7:0] code);
        return (code == EvStart) || (code == EvPlace) || (code == EvEnd);
    endfunction

    function automatic logic [1:0] payload_len(input logic [7:0] code);
        case (code)
            EvStart: return 2'd1;
            EvPlace: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic args_ok(input logic [7:0] code, input logic [7:0] a0,
                                     input logic [7:0] a1, input logic [7:0] a2);
        case (code)
            EvStart: return a0 <= 8'd2;
            EvPlace: return (a0 <= 8'd8) && (a1 <= 8'd8) && (a2 <= 8'd9);
            default: return 1'b1;
        endcase
    endfunction

    logic [0:0]  state_q, state_d;
    logic [7:0]  cur_event_q, cur_event_d;
    logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [7:0]  evento_q, evento_d;
    logic [7:0]  arg0_q, arg0_d, arg1_q, arg1_d, arg2_q, arg2_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_error_q, frame_error_d;
    logic [1:0]  err_code_q, err_code_d;

    always_comb begin
        state_d       = state_q;
        cur_event_d   = cur_event_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        byte_cnt_d    = byte_cnt_q;
        tcnt_d        = tcnt_q;
        evento_d      = evento_q;
        arg0_d        = arg0_q;
        arg1_d        = arg1_q;
        arg2_d        = arg2_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        err_code_d    = err_code_q;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (!is_known(rx_data)) begin
                        frame_error_d = 1'b1;
                        err_code_d    = ErrUnknown;
                    end else if (payload_len(rx_data) == 2'd0) begin
                        evento_d     = rx_data;
                        arg0_d       = 8'd0;
                        arg1_d       = 8'd0;
                        arg2_d       = 8'd0;
                        data_valid_d = 1'b1;
                    end else begin
                        cur_event_d = rx_data;
                        sh0_d       = 8'd0;
                        sh1_d       = 8'd0;
                        sh2_d       = 8'd0;
                        byte_cnt_d  = 2'd0;
                        tcnt_d      = 32'd0;
                        state_d     = StPayload;
                    end
                end
            end
            default: begin
                // A byte on the terminal-count cycle takes priority over the timeout.
                if (rx_valid) begin
                    case (byte_cnt_q)
                        2'd0:    sh0_d = rx_data;
                        2'd1:    sh1_d = rx_data;
                        default: sh2_d = rx_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    tcnt_d     = 32'd0;
                    if ((byte_cnt_q + 2'd1) == payload_len(cur_event_q)) begin
                        state_d = StIdle;
                        if (args_ok(cur_event_q, sh0_d, sh1_d, sh2_d)) begin
                            evento_d     = cur_event_q;
                            arg0_d       = sh0_d;
                            arg1_d       = sh1_d;
                            arg2_d       = sh2_d;
                            data_valid_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                            err_code_d    = ErrRange;
                        end
                    end
                end else if (tcnt_q == TcntLast) begin
                    frame_error_d = 1'b1;
                    err_code_d    = ErrTimeout;
                    state_d       = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cur_event_q   <= 8'd0;
            sh0_q         <= 8'd0;
            sh1_q         <= 8'd0;
            sh2_q         <= 8'd0;
            byte_cnt_q    <= 2'd0;
            tcnt_q        <= 32'd0;
            evento_q      <= 8'd0;
            arg0_q        <= 8'd0;
            arg1_q        <= 8'd0;
            arg2_q        <= 8'd0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            cur_event_q   <= cur_event_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            byte_cnt_q    <= byte_cnt_d;
            tcnt_q        <= tcnt_d;
            evento_q      <= evento_d;
            arg0_q        <= arg0_d;
            arg1_q        <= arg1_d;
            arg2_q        <= arg2_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign evento      = evento_q;
    assign arg0        = arg0_q;
    assign arg1        = arg1_q;
    assign arg2        = arg2_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q == StPayload);

endmodule

// File: doc/rx_command_decoder.md
# rx_command_decoder

Frames the byte stream from the UART receiver into complete host commands for the sudoku game core. It identifies the event code, collects the event's fixed-length payload, and range-checks the arguments. It then publishes the event and its arguments with a one-cycle `data_valid` strobe. It sits between the UART RX and the game controller and the event senders, such as the end-game sender, which consume `evento`/`data_valid`. Malformed, unknown or stalled frames are dropped and reported on `frame_error`.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: max clock cycles allowed between consecutive bytes of one frame (1 s at 50 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte, valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `evento`  out  8  event code of the last accepted frame.
- `arg0`, `arg1`, `arg2`  out  8 each  payload bytes of the last accepted frame, in arrival order; unused bytes are 0.
- `data_valid`  out  1  one-cycle strobe; `evento` and `arg*` are new and stable.
- `frame_error`  out  1  one-cycle strobe; a frame was discarded.
- `err_code`  out  2  reason for the last error: 01 unknown event, 10 argument out of range, 11 inter-byte timeout. Held until the next error.
- `busy`  out  1  high while a frame is partially received.

## Operation
- Event table, listed as code → payload length → argument rules:
  - 0xA0 START → 1 byte; arg0 is difficulty, 0..2.
  - 0xA1 PLACE → 3 bytes; arg0 is row, 0..8; arg1 is col, 0..8; arg2 is value, 0..9, where 0 erases.
  - 0xAB END_GAME → 0 bytes.
  - Any other code is unknown.
- FSM has two states: IDLE and PAYLOAD. Internal `cur_event` register; 2-bit `byte_cnt`; 32-bit timeout counter `tcnt`.
- IDLE, on `rx_valid`:
  - Known code with length 0: publish immediately.
  - Known code with length >0: latch the code into `cur_event`, clear the arg shadow registers, set `byte_cnt`=0 and `tcnt`=0, go to PAYLOAD.
  - Unknown code: `frame_error` with `err_code`=01; stay in IDLE.
- PAYLOAD, on `rx_valid`:
  - Store the byte into shadow `arg[byte_cnt]`, increment `byte_cnt`, clear `tcnt`.
  - On the last byte, check all arguments and return to IDLE.
  - If every argument is in range, publish. Otherwise raise `frame_error` with `err_code`=10.
- PAYLOAD without `rx_valid`: increment `tcnt`. When `tcnt` = `TIMEOUT_CYCLES`-1, raise `frame_error` with `err_code`=11 and go to IDLE.
- Publish means: `evento`, `arg0..2` are loaded from the code and shadow registers, and `data_valid`=1 for exactly one cycle.
- A rejected or aborted frame never changes `evento` or `arg*`.
- `busy` = (state == PAYLOAD).
- Reset values: state IDLE; `evento`, `arg0..2`, `err_code`, shadow registers, `byte_cnt` and `tcnt` all 0; `data_valid`, `frame_error` and `busy` all 0.

## Timing
- A byte accepted on edge N produces its `data_valid` or `frame_error` on the cycle after edge N, i.e. 1-cycle latency, registered.
- `data_valid` and `frame_error` are never high in the same cycle.
- Back-to-back `rx_valid` on consecutive cycles is fully supported; no byte is dropped while a strobe is being emitted.
- If `rx_valid` coincides with the timeout terminal count, the byte wins: it is accepted and `tcnt` is cleared, with no timeout.
- Payload bytes are never interpreted as event codes. An 0xAB arriving inside a PLACE payload is stored as data, then fails the range check.
- `reset` asserted mid-frame discards the partial frame, returns to IDLE at the next edge, and emits no strobe.
- `tcnt` never wraps: it saturates at the terminal count and the FSM leaves PAYLOAD on that cycle.

## Test plan
- END_GAME: byte 0xAB → next cycle `data_valid`=1, `evento`=0xAB, `arg0..2`=0, `busy` never high.
- PLACE: bytes 0xA1, 0x03, 0x07, 0x05 back-to-back → `busy`=1 for 3 cycles, then `data_valid` with `evento`=0xA1, `arg0`=3, `arg1`=7, `arg2`=5.
- Range error: 0xA1, 0x09, 0x00, 0x01 → `frame_error`, `err_code`=10; `evento`/`arg*` keep the prior PLACE values; next 0xA0, 0x02 → `data_valid`, `arg0`=2.
- Unknown: 0x55 → `frame_error`, `err_code`=01, state stays IDLE; 0xAB then decodes normally.
- Timeout (`TIMEOUT_CYCLES`=16): 0xA0 then silence → `frame_error` with `err_code`=11 exactly 16 cycles after the 0xA0 acceptance edge. Repeat with a byte arriving on the terminal cycle → the byte is accepted, followed by `data_valid`.
- Reset mid-frame: 0xA1, 0x01, then `reset` for 1 cycle, then 0xAB → no strobe from the partial frame, all outputs 0, then `data_valid` with `evento`=0xAB.
